mux_arb_n: RTL and testbench

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_arb_n_pkg.sv | 13 +
 rtl/rr_grant_n.sv | 28 ++
 rtl/mux_arb_n.sv | 100 ++++++++++
 tb/tb_mux_arb_n.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_n_pkg.sv
// Shared definitions for the N-input registered multiplexer/arbiter:
// channel-select modes and the output-stage state encoding.
package mux_arb_n_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_grant_n.sv
// Round-robin grant: one-hot grant to the first requester after ptr_i,
// scanning ptr_i+1 .. ptr_i modulo N (works for non-power-of-two N).
module rr_grant_n #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  always_comb begin
    logic [SELW-1:0] slot;
    logic            found;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt_o = '0;
    found = 1'b0;
    slot  = '0;
    for (int k = 1; k <= N; k++) begin
      slot = SELW'((int'(ptr_i) + k) % N);
      if (!found && req_i[slot]) begin
        gnt_o[slot] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with a one-word registered output stage;
// channel chosen by Sel (MODE_SEL) or by round-robin arbitration (MODE_RR).
module mux_arb_n
  import mux_arb_n_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SELW  = $clog2(N)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N*WIDTH-1:0] Din,
  input  logic [N-1:0]       DinValid,
  output logic [N-1:0]       DinReady,
  input  logic [SELW-1:0]    Sel,
  output logic [WIDTH-1:0]   Dout,
  output logic               DoutValid,
  input  logic               DoutReady,
  output logic [SELW-1:0]    DoutSrc
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0]  src_q, src_d;
  logic [N-1:0]     gnt;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             free;
  logic             accept;

  assign free     = (state_q == ST_EMPTY) || DoutReady;
  assign accept   = free && (|gnt);
  assign DinReady = (free && !RST) ? gnt : '0;

  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] ptr_q;

    rr_grant_n #(.N(N), .SELW(SELW)) u_rr_grant (
      .req_i (DinValid),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
    );

    // Reset to N-1 so the first scan starts at channel 0.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)         ptr_q <= SELW'(N - 1);
      else if (accept) ptr_q <= gnt_idx;
    end
  end else begin : g_sel
    always_comb begin
      gnt = '0;
      for (int i = 0; i < N; i++) begin
        if (Sel == SELW'(i)) gnt[i] = DinValid[i];
      end
    end
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx  = SELW'(i);
        gnt_data = Din[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    src_d   = src_q;
    if (accept) begin
      state_d = ST_FULL;
      dout_d  = gnt_data;
      src_d   = gnt_idx;
    end else if (state_q == ST_FULL && DoutReady) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      dout_q  <= '0;
      src_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
      state_q <= state_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
    end
  end

  assign Dout      = dout_q;
  assign DoutValid = (state_q == ST_FULL);
  assign DoutSrc   = src_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: four instances (select/round-robin, N=4/N=3)
// with a scoreboard queue of expected output words.
module tb_mux_arb_n;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   src;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [4*W-1:0] din0;  logic [3:0] vld0, rdy0; logic [1:0] sel0, src0;
  logic [W-1:0]   dout0; logic dv0, dr0;
  logic [3*W-1:0] din1;  logic [2:0] vld1, rdy1; logic [1:0] sel1, src1;
  logic [W-1:0]   dout1; logic dv1, dr1;
  logic [4*W-1:0] din2;  logic [3:0] vld2, rdy2; logic [1:0] sel2, src2;
  logic [W-1:0]   dout2; logic dv2, dr2;
  logic [3*W-1:0] din3;  logic [2:0] vld3, rdy3; logic [1:0] sel3, src3;
  logic [W-1:0]   dout3; logic dv3, dr3;

  mux_arb_n #(.WIDTH(W), .N(4), .MODE(0)) u_sel4 (
    .CLK(CLK), .RST(RST), .Din(din0), .DinValid(vld0), .DinReady(rdy0), .Sel(sel0),
    .Dout(dout0), .DoutValid(dv0), .DoutReady(dr0), .DoutSrc(src0));
  mux_arb_n #(.WIDTH(W), .N(3), .MODE(0)) u_sel3 (
    .CLK(CLK), .RST(RST), .Din(din1), .DinValid(vld1), .DinReady(rdy1), .Sel(sel1),
    .Dout(dout1), .DoutValid(dv1), .DoutReady(dr1), .DoutSrc(src1));
  mux_arb_n #(.WIDTH(W), .N(4), .MODE(1)) u_rr4 (
    .CLK(CLK), .RST(RST), .Din(din2), .DinValid(vld2), .DinReady(rdy2), .Sel(sel2),
    .Dout(dout2), .DoutValid(dv2), .DoutReady(dr2), .DoutSrc(src2));
  mux_arb_n #(.WIDTH(W), .N(3), .MODE(1)) u_rr3 (
    .CLK(CLK), .RST(RST), .Din(din3), .DinValid(vld3), .DinReady(rdy3), .Sel(sel3),
    .Dout(dout3), .DoutValid(dv3), .DoutReady(dr3), .DoutSrc(src3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compare one DUT output word against the oldest scoreboard entry.
  task automatic pop_check(input string tag, input logic v, input logic [W-1:0] d,
                           input logic [1:0] s);
    exp_t e;
    check({tag, ".valid"}, 64'(v), 64'd1);
    check({tag, ".sb_depth"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".data"}, 64'(d), 64'(e.data));
      check({tag, ".src"},  64'(s), 64'(e.src));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rr4_seq[5];
    int unsigned rr3_seq[4];
    rr4_seq = '{0, 1, 2, 3, 0};
    rr3_seq = '{0, 2, 0, 2};

    din0 = '0; vld0 = '0; sel0 = '0; dr0 = 1'b0;
    din1 = '0; vld1 = '0; sel1 = '0; dr1 = 1'b0;
    din2 = '0; vld2 = '0; sel2 = '0; dr2 = 1'b0;
    din3 = '0; vld3 = '0; sel3 = '0; dr3 = 1'b0;

    // Reset: outputs cleared, DinReady held low even with a valid selected channel.
    #1 RST = 1'b1;
    #1 vld0 = 4'b0001; sel0 = 2'd0; dr0 = 1'b1;
    #1;
    check("rst.rdy0",  64'(rdy0),  64'd0);
    check("rst.dv0",   64'(dv0),   64'd0);
    check("rst.dout0", 64'(dout0), 64'd0);
    check("rst.src0",  64'(src0),  64'd0);
    check("rst.dv2",   64'(dv2),   64'd0);
    tick();
    tick();
    vld0 = '0;
    RST  = 1'b0;

    // Select mode, first edge after reset release accepts channel 2.
    sel0 = 2'd2; vld0 = 4'b0100; din0[2*W +: W] = 32'hDEADBEEF; dr0 = 1'b1;
    #1 check("sel.rdy0", 64'(rdy0), 64'b0100);
    exp_q.push_back('{32'hDEADBEEF, 2'd2});
    tick();
    pop_check("sel.ch2", dv0, dout0, src0);
    vld0 = '0;
    tick();
    check("sel.drain_dv",   64'(dv0),   64'd0);
    check("sel.drain_hold", 64'(dout0), 64'hDEADBEEF);

    // Sel points at an invalid channel: no grant, no acceptance.
    sel0 = 2'd3; vld0 = 4'b0111;
    #1 check("sel.inv_rdy0", 64'(rdy0), 64'd0);
    tick();
    check("sel.inv_dv0", 64'(dv0), 64'd0);
    vld0 = '0;

    // N=3: Sel=3 is out of range and never grants.
    sel1 = 2'd3; vld1 = 3'b111; dr1 = 1'b1; din1 = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    #1 check("sel3.oor_rdy", 64'(rdy1), 64'd0);
    tick();
    check("sel3.oor_dv", 64'(dv1), 64'd0);
    sel1 = 2'd1; vld1 = 3'b010;
    exp_q.push_back('{32'h1111_1111, 2'd1});
    tick();
    pop_check("sel3.ch1", dv1, dout1, src1);
    vld1 = '0;
    tick();

    // Backpressure: hold FULL three cycles, then drain and refill with no bubble.
    sel0 = 2'd0; vld0 = 4'b0001; din0[0 +: W] = 32'hA0A0A0A0; dr0 = 1'b0;
    exp_q.push_back('{32'hA0A0A0A0, 2'd0});
    tick();
    pop_check("bp.first", dv0, dout0, src0);
    sel0 = 2'd1; vld0 = 4'b0010; din0[W +: W] = 32'hB1B1B1B1;
    for (int c = 0; c < 3; c++) begin
      check("bp.stall_rdy",  64'(rdy0),  64'd0);
      check("bp.stall_dv",   64'(dv0),   64'd1);
      check("bp.stall_dout", 64'(dout0), 64'hA0A0A0A0);
      check("bp.stall_src",  64'(src0),  64'd0);
      tick();
    end
    dr0 = 1'b1;
    #1 check("bp.release_rdy", 64'(rdy0), 64'b0010);
    exp_q.push_back('{32'hB1B1B1B1, 2'd1});
    tick();
    pop_check("bp.nobubble", dv0, dout0, src0);
    vld0 = '0;
    tick();
    check("bp.empty_dv", 64'(dv0), 64'd0);

    // Round-robin N=4, all valid: 0,1,2,3,0.
    for (int i = 0; i < 4; i++) din2[i*W +: W] = 32'h1000_0000 + i;
    vld2 = 4'b1111; dr2 = 1'b1;
    #1 check("rr4.first_rdy", 64'(rdy2), 64'b0001);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{32'h1000_0000 + rr4_seq[i], 2'(rr4_seq[i])});
      tick();
      pop_check($sformatf("rr4.step%0d", i), dv2, dout2, src2);
    end
    vld2 = '0;
    tick();

    // Round-robin N=3, channels 0 and 2 valid: 0,2,0,2 across the wrap.
    for (int i = 0; i < 3; i++) din3[i*W +: W] = 32'h3000_0000 + i;
    vld3 = 3'b101; dr3 = 1'b1;
    #1 check("rr3.first_rdy", 64'(rdy3), 64'b001);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{32'h3000_0000 + rr3_seq[i], 2'(rr3_seq[i])});
      tick();
      pop_check($sformatf("rr3.step%0d", i), dv3, dout3, src3);
    end
    vld3 = '0;
    tick();

    // Reset while FULL: immediate clear, then channel 0 wins again.
    vld2 = 4'b0100; dr2 = 1'b0;
    exp_q.push_back('{32'h1000_0002, 2'd2});
    tick();
    pop_check("rst.fill", dv2, dout2, src2);
    vld2 = '0;
    #2 RST = 1'b1;
    #1;
    check("rst.mid_dv2",   64'(dv2),   64'd0);
    check("rst.mid_dout2", 64'(dout2), 64'd0);
    tick();
    RST  = 1'b0;
    vld2 = 4'b1111; dr2 = 1'b1;
    exp_q.push_back('{32'h1000_0000, 2'd0});
    tick();
    pop_check("rst.prio0", dv2, dout2, src2);
    exp_q.push_back('{32'h1000_0001, 2'd1});
    tick();
    pop_check("rst.next1", dv2, dout2, src2);
    vld2 = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
